// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   aluop_t    - ALUOp field (add, sub, R-type by funct, multiply)
//   funct_t    - R-type function select, decoded when ALUOp = R-type
//   ex_state_t - execute-stage sequencer states (S_IDLE, S_MUL)
package ex_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_MUL   = 2'b11
  } aluop_t;

  typedef enum logic [2:0] {
    F_ADD = 3'b000,
    F_SUB = 3'b001,
    F_AND = 3'b010,
    F_OR  = 3'b011,
    F_XOR = 3'b100,
    F_SLT = 3'b101,
    F_SLL = 3'b110,
    F_SRL = 3'b111
  } funct_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } ex_state_t;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational ALU of the execute stage.
// Ports:
//   aluop  in  2        operation class (add, sub, R-type, multiply)
//   funct  in  FUNCT_W  R-type function select
//   a      in  DATA_W   operand A
//   b      in  DATA_W   operand B (already muxed by the stage)
//   y      out DATA_W   result
// The multiply class evaluates as add here; the iterative multiplier,
// when present, lives in the stage and overrides this result.
module ex_alu
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FUNCT_W = 3
) (
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  output logic [DATA_W-1:0]  y
);

  localparam int unsigned SHW = $clog2(DATA_W);

  logic [SHW-1:0] shamt;
  logic           lt_signed;

  assign shamt     = b[SHW-1:0];
  assign lt_signed = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    case (aluop_t'(aluop))
      ALUOP_ADD: y = a + b;
      ALUOP_SUB: y = a - b;
      ALUOP_MUL: y = a + b;
      ALUOP_RTYPE: begin
        case (funct_t'(funct[2:0]))
          F_ADD:   y = a + b;
          F_SUB:   y = a - b;
          F_AND:   y = a & b;
          F_OR:    y = a | b;
          F_XOR:   y = a ^ b;
          F_SLT:   y = {{(DATA_W-1){1'b0}}, lt_signed};
          F_SLL:   y = a << shamt;
          F_SRL:   y = a >> shamt;
          default: y = '0;
        endcase
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage of the 16-bit processor.
// Operand mux + ALU + branch/jump target, registered into an EX/MEM
// output register with a valid/ready handshake (1 op/cycle).
// Build option: define EX_MUL_EN to add a radix-2 shift-add multiplier
// (ALUOp=11, DATA_W steps, stalls the stage via busy). Without it,
// ALUOp=11 executes as a single-cycle add and busy is tied low.
// Ports:
//   clock, reset_n          clock (rising edge), synchronous active-low reset
//   in_valid / in_ready     ID -> EX handshake
//   Branch, ALUSrc, ALUOp   control from decode
//   funct                   R-type function select
//   dataID1, dataID2        register operands A and B
//   extdSignal, PC4         sign-extended immediate, next-instruction PC
//   out_valid / out_ready   EX -> MEM handshake
//   outputALU, Zero         registered result and (result == 0)
//   branchTaken             registered Branch & Zero
//   outputBranch            registered PC4 + (extdSignal << 1)
//   jumpResult              registered extdSignal << 1
//   busy                    multiplier iterating
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FUNCT_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               Branch,
  input  logic               ALUSrc,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  dataID1,
  input  logic [DATA_W-1:0]  dataID2,
  input  logic [DATA_W-1:0]  extdSignal,
  input  logic [DATA_W-1:0]  PC4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  outputALU,
  output logic               Zero,
  output logic               branchTaken,
  output logic [DATA_W-1:0]  outputBranch,
  output logic [DATA_W-1:0]  jumpResult,
  output logic               busy
);

  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] jmp_tgt;
  logic [DATA_W-1:0] br_tgt;
  logic              accept;
  logic              accept_alu;
  logic              consume;

  // Output-register write port: one source per cycle (ALU op or finished multiply)
  logic              wr_en;
  logic [DATA_W-1:0] wr_alu;
  logic              wr_br;
  logic [DATA_W-1:0] wr_brt;
  logic [DATA_W-1:0] wr_jmp;

  assign opb     = ALUSrc ? extdSignal : dataID2;
  assign jmp_tgt = extdSignal << 1;
  assign br_tgt  = PC4 + jmp_tgt;

  ex_alu #(
    .DATA_W (DATA_W),
    .FUNCT_W(FUNCT_W)
  ) u_alu (
    .aluop(ALUOp),
    .funct(funct),
    .a    (dataID1),
    .b    (opb),
    .y    (alu_y)
  );

  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

`ifdef EX_MUL_EN
  localparam int unsigned CNTW = $clog2(DATA_W);
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(DATA_W - 1);

  ex_state_t         state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplr_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_next;
  logic              mul_br_q;
  logic [DATA_W-1:0] mul_brt_q;
  logic [DATA_W-1:0] mul_jmp_q;
  logic              accept_mul;
  logic              mul_done;

  assign busy       = (state_q == S_MUL);
  assign accept_mul = accept && (ALUOp == ALUOP_MUL);
  assign accept_alu = accept && (ALUOp != ALUOP_MUL);
  assign acc_next   = acc_q + (mplr_q[0] ? mcand_q : '0);
  // The final step's partial sum goes straight into the output register,
  // so the product lands DATA_W cycles after the accepting edge.
  assign mul_done   = (state_q == S_MUL) && (cnt_q == LAST_STEP);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      mul_br_q  <= 1'b0;
      mul_brt_q <= '0;
      mul_jmp_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_mul) begin
            state_q   <= S_MUL;
            cnt_q     <= '0;
            mcand_q   <= dataID1;
            mplr_q    <= opb;
            acc_q     <= '0;
            // Targets/branch flag are captured now; the output register may
            // still hold an earlier result until the product is written.
            mul_br_q  <= Branch;
            mul_brt_q <= br_tgt;
            mul_jmp_q <= jmp_tgt;
          end
        end
        S_MUL: begin
          acc_q   <= acc_next;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (mul_done) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en  = accept_alu;
    wr_alu = alu_y;
    wr_br  = Branch;
    wr_brt = br_tgt;
    wr_jmp = jmp_tgt;
    if (mul_done) begin
      wr_en  = 1'b1;
      wr_alu = acc_next;
      wr_br  = mul_br_q;
      wr_brt = mul_brt_q;
      wr_jmp = mul_jmp_q;
    end
  end
`else
  assign busy       = 1'b0;
  assign accept_alu = accept;

  always_comb begin
    wr_en  = accept_alu;
    wr_alu = alu_y;
    wr_br  = Branch;
    wr_brt = br_tgt;
    wr_jmp = jmp_tgt;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      outputALU    <= '0;
      Zero         <= 1'b0;
      branchTaken  <= 1'b0;
      outputBranch <= '0;
      jumpResult   <= '0;
    end else begin
      if (wr_en) begin
        out_valid    <= 1'b1;
        outputALU    <= wr_alu;
        Zero         <= (wr_alu == '0);
        branchTaken  <= wr_br && (wr_alu == '0);
        outputBranch <= wr_brt;
        jumpResult   <= wr_jmp;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
